// File: rtl/lr35902_pkg.sv
// Shared LR35902 constants: interrupt bit indices, register addresses, vector layout.
// No logic; dispatch address helper is purely combinational.
package lr35902_pkg;

  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;
  localparam int INT_COUNT  = 5;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam logic [7:0] VEC_BASE   = 8'h40;
  localparam int         VEC_STRIDE = 8;

  function automatic logic [7:0] vec_addr(input logic [2:0] idx);
    vec_addr = VEC_BASE | 8'(int'(idx) * VEC_STRIDE);
  endfunction

endpackage

// File: rtl/lr35902_int_prio.sv
// Lowest-index-wins priority encoder over the pending interrupt vector.
// Purely combinational, zero latency; idx is 0 when nothing is pending.
module lr35902_int_prio
  import lr35902_pkg::*;
(
  input  logic [INT_COUNT-1:0] req,
  output logic                 any,
  output logic [2:0]           idx
);

  always_comb begin
    any = |req;
    idx = 3'd0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = INT_COUNT - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lr35902_int.sv
// LR35902 interrupt controller: IF/IE registers, prioritised request, ack dispatch.
// Requests visible one edge after the irq pulse; writes commit on the edge after write falls.
module lr35902_int
  import lr35902_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       adr,
  input  logic       read,
  input  logic       write,
  output logic [7:0] dout,
  input  logic [4:0] irq_in,
  output logic       int_req,
  output logic [2:0] int_vec,
  input  logic       int_ack,
  output logic [7:0] int_adr
);

  logic [INT_COUNT-1:0] if_q, if_d;
  logic [7:0]           ie_q, ie_d;
  logic [7:0]           dout_q, dout_d;
  logic [7:0]           int_adr_q, int_adr_d;
  logic                 pwrite_q, pread_q;

  logic [INT_COUNT-1:0] pending;
  logic                 wr_commit;
  logic                 rd_start;

  assign pending   = if_q & ie_q[INT_COUNT-1:0];
  assign wr_commit = pwrite_q & ~write;
  assign rd_start  = read & ~pread_q;

  lr35902_int_prio u_prio (
    .req (pending),
    .any (int_req),
    .idx (int_vec)
  );

  always_comb begin
    if_d      = if_q;
    ie_d      = ie_q;
    dout_d    = dout_q;
    int_adr_d = int_adr_q;

    // Precedence rises top to bottom: ack clear, then IF write, then hardware set.
    if (int_ack) begin
      if (int_req) begin
        if_d[int_vec] = 1'b0;
        int_adr_d     = vec_addr(int_vec);
      end else begin
        int_adr_d = 8'h00;
      end
    end
    if (wr_commit) begin
      if (adr) ie_d = din;
      else     if_d = din[INT_COUNT-1:0];
    end
    if_d = if_d | irq_in;

    if (rd_start) begin
      dout_d = adr ? ie_q : {3'b111, if_q};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_q      <= '0;
      ie_q      <= 8'h00;
      dout_q    <= 8'h00;
      int_adr_q <= 8'h00;
      pwrite_q  <= 1'b0;
      pread_q   <= 1'b0;
    end else begin
      if_q      <= if_d;
      ie_q      <= ie_d;
      dout_q    <= dout_d;
      int_adr_q <= int_adr_d;
      pwrite_q  <= write;
      pread_q   <= read;
    end
  end

  assign dout    = dout_q;
  assign int_adr = int_adr_q;

endmodule

// File: doc/lr35902_int.md
# lr35902_int

Interrupt controller for the LR35902 core: the receiving end of the one-cycle `irq` pulses raised by the timer, serial, joypad and video blocks. Latches requests into IF (FF0F), masks them with IE (FFFF), and presents the highest-priority pending request to the CPU core. The CPU dispatches it with a one-cycle acknowledge. It sits on the same CPU peripheral bus as the timer and uses the same read/write strobe conventions.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  write data from CPU.
- `adr`  in  1  register select: 0 = IF (FF0F), 1 = IE (FFFF).
- `read`  in  1  read strobe, held high for the access.
- `write`  in  1  write strobe, held high for the access.
- `dout`  out  8  read data, registered.
- `irq_in`  in  5  request pulses. Bit 0 vblank, 1 stat, 2 timer, 3 serial, 4 joypad.
- `int_req`  out  1  at least one enabled request is pending. Also serves as the HALT wake-up.
- `int_vec`  out  3  index of the highest-priority pending request, 0..4; 0 when none.
- `int_ack`  in  1  one-cycle dispatch acknowledge from the CPU.
- `int_adr`  out  8  low byte of the dispatch target, captured at acknowledge.

## Operation
- **IF register** (`if_r`, 5 bits)
  - Any cycle with `irq_in[n]` high sets `if_r[n]`.
  - A pulse longer than one cycle simply re-sets the bit.
- **IE register** (`ie_r`): 8 bits, all stored. Only bits 4:0 take part in masking.
- **Pending and priority**
  - pending = `if_r & ie_r[4:0]`.
  - `int_req` = OR of pending.
  - `int_vec` = lowest set index of pending; bit 0 has the highest priority.
- **Writes**
  - A write commits on the first `clk` edge where `write` is low and `write` was high on the previous edge. The previous value is kept in the registered `pwrite`.
  - The commit uses the `adr`/`din` sampled at that edge.
  - IF write: `if_r <= din[4:0]`. IE write: `ie_r <= din`.
- **Reads**
  - `dout` is loaded on the edge where `read` is high and the registered `pread` is low.
  - IF reads as `{3'b111, if_r}`; IE reads as `ie_r`.
  - Otherwise `dout` holds its value.
- **Acknowledge**
  - On an edge with `int_ack` high and `int_req` high: clear `if_r[int_vec]` and set `int_adr <= 8'h40 | (int_vec << 3)`.
  - On an edge with `int_ack` high and `int_req` low: no bit is cleared and `int_adr <= 8'h00`. This is the cancelled dispatch; the CPU jumps to 0000.
- **Simultaneous events**, in order of increasing precedence:
  1. Acknowledge clear.
  2. IF write.
  3. Hardware set from `irq_in`.
  - A request pulse arriving on the same edge as its own acknowledge or its own IF-write-to-0 leaves the bit set.
  - An IE write and an acknowledge on the same edge: the acknowledge uses the pre-write pending value.
- IME is not held here; the CPU core gates dispatch with IME itself.

## Timing
- Reset (`reset_n` low, asynchronous): `if_r`=0, `ie_r`=0, `dout`=8'h00, `int_adr`=8'h00, `pwrite`=0, `pread`=0. As a result `int_req`=0 and `int_vec`=0.
- Request latency: an `irq_in` pulse on edge N makes `int_req` high after edge N, provided the request is enabled. `int_req` and `int_vec` are combinational from `if_r`/`ie_r`.
- Write latency: the register changes on the edge after `write` falls. A read must start at least one cycle after that edge to see the new value.
- Read latency: `dout` is valid after the first edge with `read` high.
- Acknowledge: `int_adr` is valid and the IF bit is cleared after the ack edge. `int_req` then reflects the next pending request, if any, with no idle cycle.
- Reset asserted mid-access or mid-ack aborts it; no partial commit.

## Structure
- Shared package `lr35902_pkg` holds:
  - Interrupt bit index constants (`INT_VBLANK`..`INT_JOYPAD`).
  - `INT_COUNT`=5.
  - Register addresses 16'hFF0F/16'hFFFF.
  - Vector base 8'h40 and vector stride 8.
- One combinational sub-module, `lr35902_int_prio`: a 5-bit lowest-index priority encoder with outputs `any`, `idx[2:0]`.
- Register file, strobe edge detection and acknowledge logic live in the top module.

## Test plan
- **Reset and readback:** pulse `reset_n` low, then read IF and IE -> 8'hE0 and 8'h00; `int_req`=0.
- **Masked request:**
  - Write IE=8'h04, then pulse `irq_in[2]` for one cycle -> `int_req`=1, `int_vec`=2.
  - Ack -> `int_adr`=8'h50, IF reads 8'hE0, `int_req`=0.
- **Priority:**
  - IE=8'h1F; pulse bits 4 and 1 together -> `int_vec`=1.
  - Ack -> `int_adr`=8'h48 and `int_vec`=4 on the next cycle.
  - Second ack -> `int_adr`=8'h60.
- **Cancelled dispatch:** IE=8'h01 with vblank pending; write IE=8'h00, then ack -> `int_adr`=8'h00 and IF still reads 8'hE1.
- **Set wins:**
  - Ack the timer request on the same edge `irq_in[2]` pulses again -> IF bit 2 stays 1, `int_req` stays 1.
  - Write IF=8'h00 on the same edge as a serial pulse -> IF reads 8'hE8.
- **Masking and software set:** with IE=8'h00, write IF=8'h1F -> `int_req`=0 and IF reads 8'hFF. Then write IE=8'h10 -> `int_req`=1, `int_vec`=4.
